// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   D-stage branch resolution for the pipelined MIPS core. It evaluates one of
//   eight compare modes on the forwarded rs/rt operands. While a required
//   operand is still in flight, it holds the request in WAIT and raises
//   stall_req. The jump decision is registered and appears as a one-cycle
//   out_valid pulse, one cycle after the operands are ready.
//
// Optional feature macro: BRANCH_STATS_EN
//   Defined   : saturating counters for resolved branches, taken branches and
//               WAIT cycles.
//   Undefined : br_cnt, taken_cnt and wait_cnt are tied to 0. The port list
//               is the same in both builds.
//
// Parameters
//   WIDTH  operand width (two's complement for the zero-relative modes)
//   CNT_W  statistics counter width
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   flush      synchronous kill of any in-flight request
//   in_valid   branch instruction present in D stage
//   cmp_op     0 eq, 1 ne, 2 lez, 3 gtz, 4 ltz, 5 gez, 6 always, 7 never
//   rs_val     forwarded rs operand
//   rt_val     forwarded rt operand
//   rs_ready   rs_val is final
//   rt_ready   rt_val is final
//   stall_req  hold IF/D this cycle (combinational)
//   out_valid  one-cycle pulse: decision available
//   jump       branch taken; 0 whenever out_valid is 0
//   br_cnt     resolved branches
//   taken_cnt  taken branches
//   wait_cnt   cycles spent in WAIT
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [2:0]       cmp_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             rs_ready,
  input  logic             rt_ready,
  output logic             stall_req,
  output logic             out_valid,
  output logic             jump,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [2:0] OP_EQ     = 3'd0;
  localparam logic [2:0] OP_NE     = 3'd1;
  localparam logic [2:0] OP_LEZ    = 3'd2;
  localparam logic [2:0] OP_GTZ    = 3'd3;
  localparam logic [2:0] OP_LTZ    = 3'd4;
  localparam logic [2:0] OP_GEZ    = 3'd5;
  localparam logic [2:0] OP_ALWAYS = 3'd6;

  localparam logic signed [WIDTH-1:0] ZERO = '0;

  // Operand readiness: two-operand compares need both, zero-relative ones
  // need rs only, always/never need nothing.
  function automatic logic need_ok_f(input logic [2:0] op,
                                     input logic       rsr,
                                     input logic       rtr);
    case (op)
      OP_EQ, OP_NE:                   return rsr & rtr;
      OP_LEZ, OP_GTZ, OP_LTZ, OP_GEZ: return rsr;
      default:                        return 1'b1;
    endcase
  endfunction

  function automatic logic result_f(input logic [2:0]       op,
                                    input logic [WIDTH-1:0] rs,
                                    input logic [WIDTH-1:0] rt);
    case (op)
      OP_EQ:     return rs == rt;
      OP_NE:     return rs != rt;
      OP_LEZ:    return $signed(rs) <= ZERO;
      OP_GTZ:    return $signed(rs) >  ZERO;
      OP_LTZ:    return rs[WIDTH-1];
      OP_GEZ:    return ~rs[WIDTH-1];
      OP_ALWAYS: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [2:0] sel_op;
  logic       active;
  logic       need_ok;
  logic       resolve;
  logic       result;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments. Every flop then
  // samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= 3'd0;
      out_valid <= 1'b0;
      jump      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      out_valid <= resolve;
      jump      <= resolve & result;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first. A missing branch
  // then cannot infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && !need_ok) begin
            state_d = WAIT;
            op_d    = cmp_op;
          end
        end
        WAIT: begin
          if (need_ok) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output / datapath logic
  // -------------------------------------------------------------------------
  // In WAIT the latched op is used and the live cmp_op/in_valid are ignored.
  // The operands and ready flags are still taken live every cycle.
  always_comb begin
    sel_op    = (state_q == WAIT) ? op_q : cmp_op;
    active    = (state_q == WAIT) | in_valid;
    need_ok   = need_ok_f(sel_op, rs_ready, rt_ready);
    result    = result_f(sel_op, rs_val, rt_val);
    stall_req = active & ~need_ok;
    // A resolution coinciding with flush is dropped and leaves no trace.
    resolve   = active & need_ok & ~flush;
  end

  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
`ifdef BRANCH_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // The counters update at the same edge that raises out_valid, so they
  // already include the pulse that is currently visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (resolve && (br_cnt != '1))
        br_cnt <= br_cnt + CNT_ONE;
      if (resolve && result && (taken_cnt != '1))
        taken_cnt <= taken_cnt + CNT_ONE;
      if ((state_q == WAIT) && !flush && (wait_cnt != '1))
        wait_cnt <= wait_cnt + CNT_ONE;
    end
  end
`else
  assign br_cnt    = '0;
  assign taken_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//   Directed bench for branch_resolve_unit with WIDTH=32 and CNT_W=4.
//   Expected counter values depend on whether BRANCH_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic [2:0]       cmp_op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             rs_ready;
  logic             rt_ready;
  logic             stall_req;
  logic             out_valid;
  logic             jump;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] wait_cnt;

  int total = 0;
  int bad   = 0;

  branch_resolve_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .cmp_op    (cmp_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .rs_ready  (rs_ready),
    .rt_ready  (rt_ready),
    .stall_req (stall_req),
    .out_valid (out_valid),
    .jump      (jump),
    .br_cnt    (br_cnt),
    .taken_cnt (taken_cnt),
    .wait_cnt  (wait_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [CNT_W-1:0] exp_cnt(input int v);
    return STATS ? CNT_W'(v) : '0;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    flush    = 1'b0;
    in_valid = 1'b0;
    cmp_op   = 3'd0;
    rs_val   = '0;
    rt_val   = '0;
    rs_ready = 1'b1;
    rt_ready = 1'b1;
  endtask

  task automatic reset_dut;
    idle_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
  endtask

  task automatic check_cnt(input string name, input int eb, input int et, input int ew);
    total++;
    if (br_cnt !== exp_cnt(eb) || taken_cnt !== exp_cnt(et) || wait_cnt !== exp_cnt(ew)) begin
      bad++;
      $display("FAIL %s: counters br/taken/wait got %0d/%0d/%0d want %0d/%0d/%0d",
               name, br_cnt, taken_cnt, wait_cnt, exp_cnt(eb), exp_cnt(et), exp_cnt(ew));
    end
  endtask

  // Issue one request and expect it to resolve without a stall.
  task automatic resolve_one(input logic [2:0] op, input logic [WIDTH-1:0] rs,
                             input logic [WIDTH-1:0] rt, input logic rsr, input logic rtr,
                             input logic exp_j, input string name);
    in_valid = 1'b1;
    cmp_op   = op;
    rs_val   = rs;
    rt_val   = rt;
    rs_ready = rsr;
    rt_ready = rtr;
    #1;
    total++;
    if (stall_req !== 1'b0) begin
      bad++;
      $display("FAIL %s stall: got %b want 0", name, stall_req);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || jump !== exp_j) begin
      bad++;
      $display("FAIL %s: out_valid=%b jump=%b want out_valid=1 jump=%b",
               name, out_valid, jump, exp_j);
    end
    in_valid = 1'b0;
    rs_ready = 1'b1;
    rt_ready = 1'b1;
  endtask

  task automatic check_quiet(input string name);
    step();
    total++;
    if (out_valid !== 1'b0 || jump !== 1'b0) begin
      bad++;
      $display("FAIL %s: out_valid=%b jump=%b want 0/0", name, out_valid, jump);
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || jump !== 1'b0 || stall_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ov=%b j=%b stall=%b want 0/0/0", out_valid, jump, stall_req);
    end
    check_cnt("reset_cnt", 0, 0, 0);
    step();
    reset = 1'b0;
    step();
    // Async clear of a live out_valid pulse.
    resolve_one(3'd6, '0, '0, 1'b0, 1'b0, 1'b1, "pre_reset_always");
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || jump !== 1'b0) begin
      bad++;
      $display("FAIL reset_async_pulse: ov=%b j=%b want 0/0", out_valid, jump);
    end
    reset = 1'b0;
    step();
    // Enter WAIT on eq with rs not ready, then reset mid-cycle.
    in_valid = 1'b1;
    cmp_op   = 3'd0;
    rs_ready = 1'b0;
    rt_ready = 1'b1;
    #1;
    total++;
    if (stall_req !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_wait_stall: got %b want 1", stall_req);
    end
    step();
    in_valid = 1'b0;
    #1;
    total++;
    if (stall_req !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_wait_stall: got %b want 1", stall_req);
    end
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || jump !== 1'b0 || stall_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_wait: ov=%b j=%b stall=%b want 0/0/0", out_valid, jump, stall_req);
    end
    #2;
    reset = 1'b0;
    // If still in WAIT, readying rs would produce a pulse.
    rs_ready = 1'b1;
    check_quiet("reset_idle_after");
  endtask

  task automatic test_eq_ne;
    resolve_one(3'd0, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 1'b1, "eq_equal");
    resolve_one(3'd0, 32'h1234_5678, 32'h1234_5679, 1'b1, 1'b1, 1'b0, "eq_differ");
    resolve_one(3'd1, 32'h1234_5678, 32'h1234_5679, 1'b1, 1'b1, 1'b1, "ne_differ");
    resolve_one(3'd1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 1'b0, "ne_equal");
    check_quiet("eq_ne_pulse_drop");
  endtask

  task automatic test_signed;
    // rt is not needed by the zero-relative modes, so it is held not-ready.
    resolve_one(3'd4, 32'h8000_0000, '0, 1'b1, 1'b0, 1'b1, "ltz_min");
    resolve_one(3'd2, 32'h8000_0000, '0, 1'b1, 1'b0, 1'b1, "lez_min");
    resolve_one(3'd5, 32'h8000_0000, '0, 1'b1, 1'b0, 1'b0, "gez_min");
    resolve_one(3'd3, 32'h8000_0000, '0, 1'b1, 1'b0, 1'b0, "gtz_min");
    resolve_one(3'd2, 32'h0000_0000, '0, 1'b1, 1'b0, 1'b1, "lez_zero");
    resolve_one(3'd5, 32'h0000_0000, '0, 1'b1, 1'b0, 1'b1, "gez_zero");
    resolve_one(3'd3, 32'h0000_0000, '0, 1'b1, 1'b0, 1'b0, "gtz_zero");
    resolve_one(3'd4, 32'h0000_0000, '0, 1'b1, 1'b0, 1'b0, "ltz_zero");
    resolve_one(3'd3, 32'h7FFF_FFFF, '0, 1'b1, 1'b0, 1'b1, "gtz_max");
    resolve_one(3'd2, 32'h7FFF_FFFF, '0, 1'b1, 1'b0, 1'b0, "lez_max");
    resolve_one(3'd3, 32'hFFFF_FFFF, '0, 1'b1, 1'b0, 1'b0, "gtz_minus1");
    resolve_one(3'd6, 32'h0000_0005, 32'h9, 1'b0, 1'b0, 1'b1, "always_unready");
    resolve_one(3'd7, 32'h0000_0005, 32'h5, 1'b0, 1'b0, 1'b0, "never_unready");
    check_quiet("signed_pulse_drop");
  endtask

  task automatic test_wait_latch;
    reset_dut();
    // eq on 5 vs 6 gives 0; gtz on 5 would give 1, which exposes a wrong op.
    in_valid = 1'b1;
    cmp_op   = 3'd0;
    rs_val   = 32'd5;
    rt_val   = 32'd6;
    rs_ready = 1'b1;
    rt_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (stall_req !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL wait_stall_c%0d: stall=%b ov=%b want 1/0", c, stall_req, out_valid);
      end
      step();
      cmp_op = 3'd3;
    end
    rt_ready = 1'b1;
    in_valid = 1'b0;
    #1;
    total++;
    if (stall_req !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL wait_ready_cycle: stall=%b ov=%b want 0/0", stall_req, out_valid);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || jump !== 1'b0) begin
      bad++;
      $display("FAIL wait_resolve_latched_eq: ov=%b j=%b want 1/0", out_valid, jump);
    end
    check_cnt("wait_cnt3", 1, 0, 3);
    check_quiet("wait_pulse_drop");
  endtask

  task automatic test_flush;
    in_valid = 1'b1;
    cmp_op   = 3'd1;
    rs_val   = 32'd1;
    rt_val   = 32'd2;
    rs_ready = 1'b1;
    rt_ready = 1'b0;
    step();
    in_valid = 1'b0;
    rt_ready = 1'b1;
    flush    = 1'b1;
    #1;
    step();
    flush = 1'b0;
    total++;
    if (out_valid !== 1'b0 || jump !== 1'b0) begin
      bad++;
      $display("FAIL flush_suppress: ov=%b j=%b want 0/0", out_valid, jump);
    end
    // If WAIT survived the flush, the ready operands would fire now.
    check_quiet("flush_idle_after");
    check_cnt("flush_cnt", 1, 0, 3);
    resolve_one(3'd1, 32'd1, 32'd2, 1'b1, 1'b1, 1'b1, "ne_after_flush");
    check_cnt("after_flush_cnt", 2, 1, 3);
  endtask

  task automatic test_back_to_back;
    int exp_n;
    reset_dut();
    in_valid = 1'b1;
    cmp_op   = 3'd6;
    rs_ready = 1'b0;
    rt_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || jump !== 1'b1) begin
        bad++;
        $display("FAIL b2b_pulse_%0d: ov=%b j=%b want 1/1", i, out_valid, jump);
      end
      exp_n = (i + 1 > 15) ? 15 : i + 1;
      check_cnt($sformatf("b2b_cnt_%0d", i), exp_n, exp_n, 0);
    end
    in_valid = 1'b0;
    check_quiet("b2b_end");
    check_cnt("b2b_saturated", 15, 15, 0);
  endtask

  initial begin
    test_reset();
    test_eq_ne();
    test_signed();
    test_wait_latch();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised D-stage branch resolution unit for the pipelined MIPS core; successor to the single-mode equality comparator.
- Supports eight compare modes (eq, ne, lez, gtz, ltz, gez, always, never) at configurable width.
- Waits for forwarded operands through a small FSM, requesting a pipeline stall meanwhile.
- Delivers a registered, one-cycle-valid jump decision to the PC/NPC logic.

Parameters:
WIDTH, 32, operand width in bits (signed two's complement for the zero-relative modes)
CNT_W, 32, width of the statistics counters (used only with BRANCH_STATS_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of any in-flight request
in_valid  input  1  branch instruction present in D stage
cmp_op  input  3  000 eq, 001 ne, 010 lez, 011 gtz, 100 ltz, 101 gez, 110 always, 111 never
rs_val  input  WIDTH  forwarded rs operand
rt_val  input  WIDTH  forwarded rt operand
rs_ready  input  1  rs_val holds final value (no pending producer)
rt_ready  input  1  rt_val holds final value
stall_req  output  1  hold IF/D stages this cycle
out_valid  output  1  one-cycle pulse: decision available
jump  output  1  branch taken; meaningful only while out_valid=1, else 0
br_cnt  output  CNT_W  resolved branches
taken_cnt  output  CNT_W  taken branches
wait_cnt  output  CNT_W  cycles spent in WAIT

Behaviour:
- Reset (async, any state): state=IDLE, out_valid=0, jump=0, op_q=0, all counters=0.
- Operand need: eq/ne need rs and rt; lez/gtz/ltz/gez need rs only; always/never need nothing. need_ok = readiness of every required operand.
- Result function:
  - eq: rs==rt; ne: rs!=rt.
  - lez: signed rs<=0; gtz: signed rs>0; ltz: rs[WIDTH-1]; gez: !rs[WIDTH-1].
  - always: 1; never: 0.
- FSM states: IDLE, WAIT.
- IDLE:
  - in_valid & need_ok: next cycle out_valid=1, jump=result; stay IDLE.
  - in_valid & !need_ok: latch op_q=cmp_op, go WAIT.
  - !in_valid: out_valid=0 next cycle.
- WAIT:
  - Compare uses latched op_q; rs_val/rt_val and ready flags re-sampled every cycle from inputs.
  - in_valid/cmp_op ignored.
  - When need_ok(op_q): next cycle out_valid=1, jump=result(op_q); go IDLE.
- stall_req (combinational) = (IDLE & in_valid & !need_ok(cmp_op)) | (WAIT & !need_ok(op_q)). Deasserts in the cycle operands become ready.
- Latency: 1 cycle from operands ready to out_valid.
- Back-to-back: a new in_valid in the same cycle as an out_valid pulse is accepted normally; this gives one decision per cycle.
- out_valid is a pulse. It drops the following cycle unless a new resolution occurs.
- flush: synchronous; priority over all except reset. Next state is IDLE, out_valid=0, jump=0. The pending request is discarded and counters are not incremented. A resolution in the same cycle as flush is suppressed.
- Width rules: operands compared at full WIDTH; signed compares use $signed. WIDTH=1 is legal; rs=1 is then negative.

Optional Feature:
BRANCH_STATS_EN
- Defined:
  - br_cnt increments on every out_valid pulse.
  - taken_cnt increments on every out_valid & jump.
  - wait_cnt increments on every clock in WAIT that is not flushed.
  - All three saturate at 2^CNT_W-1, never wrap, and clear only on reset.
- Undefined: counter logic is removed; br_cnt, taken_cnt and wait_cnt are tied to 0. Port list is unchanged.

Test Plan:
1. Reset asserted mid-WAIT (op=eq, rs_ready=0) -> out_valid=0, jump=0, stall_req=0 immediately (async); state IDLE after release.
2. eq with rs=rt=0x1234_5678, both ready -> no stall; next cycle out_valid=1, jump=1. Repeat with rt=0x1234_5679 -> jump=0. ne with the same pair -> jump=1.
3. Signed boundaries, WIDTH=32, rs_ready=1:
   - rs=0x8000_0000: ltz=1, lez=1, gez=0, gtz=0.
   - rs=0: lez=1, gez=1, gtz=0, ltz=0.
   - rs=0x7FFF_FFFF: gtz=1.
   - always=1, never=0, regardless of ready flags.
4. eq with rt_ready=0 for 3 cycles, cmp_op changed to gtz during the wait -> stall_req=1 for 3 cycles, wait_cnt=3. Result uses latched eq; out_valid the cycle after rt_ready rises.
5. WAIT with flush=1 in the same cycle operands become ready -> no out_valid pulse, state IDLE, br_cnt unchanged. Subsequent ne request resolves normally.
6. BRANCH_STATS_EN, CNT_W=4: 20 back-to-back "always" branches -> one out_valid per cycle; br_cnt and taken_cnt saturate at 15. Without the macro, all counters read 0.
